video_timing_gen: RTL and testbench

//  Source end of the pixel-stream interface consumed by the line-buffer/filter chain.

---
 rtl/video_timing_gen.sv | 135 +++++++++++++
 tb/tb_video_timing_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running H/V video timing generator with selectable test patterns
// All outputs are registered one cycle behind the counters so pixel data and VDE stay aligned.
module video_timing_gen #(
  parameter int XADRSWidth = 11,
  parameter int YADRSWidth = 10,
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_Enable,
  input  logic [1:0]  i_Pattern,
  output logic [23:0] o_pixelData,
  output logic        o_HSync,
  output logic        o_VSync,
  output logic        o_HBlank,
  output logic        o_VBlank,
  output logic        o_VDE,
  output logic        o_FrameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XADRSWidth-1:0] H_LAST     = XADRSWidth'(H_TOTAL - 1);
  localparam logic [XADRSWidth-1:0] H_ACT_END  = XADRSWidth'(H_ACTIVE);
  localparam logic [XADRSWidth-1:0] HS_START   = XADRSWidth'(H_ACTIVE + H_FP);
  localparam logic [XADRSWidth-1:0] HS_END     = XADRSWidth'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XADRSWidth-1:0] BAR_W      = XADRSWidth'(H_ACTIVE / 8);
  localparam logic [XADRSWidth-1:0] BAR_MAX    = XADRSWidth'(7);

  localparam logic [YADRSWidth-1:0] V_LAST     = YADRSWidth'(V_TOTAL - 1);
  localparam logic [YADRSWidth-1:0] V_ACT_END  = YADRSWidth'(V_ACTIVE);
  localparam logic [YADRSWidth-1:0] VS_START   = YADRSWidth'(V_ACTIVE + V_FP);
  localparam logic [YADRSWidth-1:0] VS_END     = YADRSWidth'(V_ACTIVE + V_FP + V_SYNC);

  logic [XADRSWidth-1:0] h;
  logic [YADRSWidth-1:0] v;
  logic [1:0]            pat_q;

  logic                  h_act;
  logic                  v_act;
  logic                  hs_act;
  logic                  vs_act;
  logic                  frame_first;
  logic [1:0]            pat_eff;
  logic [XADRSWidth-1:0] bar_idx;
  logic [2:0]            bar_sel;
  logic [23:0]           pix;

  always_comb begin
    h_act       = (h < H_ACT_END);
    v_act       = (v < V_ACT_END);
    hs_act      = (h >= HS_START) && (h < HS_END);
    vs_act      = (v >= VS_START) && (v < VS_END);
    frame_first = (h == '0) && (v == '0);
    // The frame-start pixel already uses the newly selected pattern, so a frame is never mixed.
    pat_eff     = frame_first ? i_Pattern : pat_q;
    bar_idx     = h / BAR_W;
    bar_sel     = (bar_idx > BAR_MAX) ? 3'd7 : bar_idx[2:0];
    pix         = '0;
    case (pat_eff)
      2'd0: begin
        case (bar_sel)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd1:    pix = {3{h[7:0]}};
      2'd2:    pix = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
      default: pix = 24'h808080;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      h <= '0;
      v <= '0;
    end else if (!i_Enable) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pat_q        <= '0;
      o_pixelData  <= '0;
      o_HSync      <= ~SYNC_POL;
      o_VSync      <= ~SYNC_POL;
      o_HBlank     <= 1'b1;
      o_VBlank     <= 1'b1;
      o_VDE        <= 1'b0;
      o_FrameStart <= 1'b0;
    end else if (!i_Enable) begin
      o_pixelData  <= '0;
      o_HSync      <= ~SYNC_POL;
      o_VSync      <= ~SYNC_POL;
      o_HBlank     <= 1'b1;
      o_VBlank     <= 1'b1;
      o_VDE        <= 1'b0;
      o_FrameStart <= 1'b0;
    end else begin
      if (frame_first) begin
        pat_q <= i_Pattern;
      end
      o_pixelData  <= (h_act && v_act) ? pix : 24'h000000;
      o_HSync      <= hs_act ? SYNC_POL : ~SYNC_POL;
      o_VSync      <= vs_act ? SYNC_POL : ~SYNC_POL;
      o_HBlank     <= ~h_act;
      o_VBlank     <= ~v_act;
      o_VDE        <= h_act && v_act;
      o_FrameStart <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen on a reduced raster
// Raster: 128+6+4+8 = 146 clocks per line, 40+2+3+4 = 49 lines per frame.
module tb_video_timing_gen;

  localparam int H_A = 128;
  localparam int H_T = 146;
  localparam int V_A = 40;
  localparam int V_T = 49;
  localparam int F_T = H_T * V_T;

  logic        Clock;
  logic        Reset;
  logic        i_Enable;
  logic [1:0]  i_Pattern;
  logic [23:0] o_pixelData;
  logic        o_HSync;
  logic        o_VSync;
  logic        o_HBlank;
  logic        o_VBlank;
  logic        o_VDE;
  logic        o_FrameStart;

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] fb [0:V_T-1][0:H_T-1];
  int vde_n, hs_n, vs_n, hb_n, vb_n, fs_n, fs_first, hs_first, vs_first;
  int blank_px, de_bad, vde_rises, rise_a, rise_b;

  video_timing_gen #(
    .XADRSWidth(8), .YADRSWidth(6),
    .H_ACTIVE(H_A), .H_FP(6), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(V_A), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .SYNC_POL(1'b1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .i_Enable(i_Enable),
    .i_Pattern(i_Pattern),
    .o_pixelData(o_pixelData),
    .o_HSync(o_HSync),
    .o_VSync(o_VSync),
    .o_HBlank(o_HBlank),
    .o_VBlank(o_VBlank),
    .o_VDE(o_VDE),
    .o_FrameStart(o_FrameStart)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pixel, hsync, vsync, hblank, vblank, vde, framestart}
  function automatic logic [31:0] out_vec();
    return {2'b00, o_pixelData, o_HSync, o_VSync, o_HBlank, o_VBlank, o_VDE, o_FrameStart};
  endfunction

  localparam logic [31:0] IDLE_VEC = {2'b00, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Samples one whole frame; index i is the output after the (i+1)-th enabled edge of the frame.
  task automatic scan_frame(input int chg_line, input logic [1:0] chg_pat);
    logic prev_vde;
    vde_n = 0; hs_n = 0; vs_n = 0; hb_n = 0; vb_n = 0; fs_n = 0;
    fs_first = -1; hs_first = -1; vs_first = -1;
    blank_px = 0; de_bad = 0; vde_rises = 0; rise_a = -1; rise_b = -1;
    prev_vde = 1'b0;
    for (int i = 0; i < F_T; i++) begin
      @(negedge Clock);
      if (i == chg_line * H_T) i_Pattern = chg_pat;
      fb[i / H_T][i % H_T] = o_pixelData;
      if (o_VDE) vde_n++;
      if (o_HSync) hs_n++;
      if (o_VSync) vs_n++;
      if (o_HBlank) hb_n++;
      if (o_VBlank) vb_n++;
      if (o_FrameStart) begin
        fs_n++;
        if (fs_first < 0) fs_first = i;
      end
      if (!o_VDE && o_pixelData != 24'h0) blank_px++;
      if (o_VDE !== (!o_HBlank && !o_VBlank)) de_bad++;
      if (o_HSync && hs_first < 0) hs_first = i;
      if (o_VSync && vs_first < 0) vs_first = i;
      if (o_VDE && !prev_vde) begin
        vde_rises++;
        if (rise_a < 0) rise_a = i;
        else if (rise_b < 0) rise_b = i;
      end
      prev_vde = o_VDE;
    end
  endtask

  initial begin
    Reset     = 1'b0;
    i_Enable  = 1'b1;
    i_Pattern = 2'd0;

    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      check("reset_idle", out_vec(), IDLE_VEC);
    end
    Reset = 1'b1;

    // Frame 0: bars; switch to grey ramp at line 20 (takes effect next frame)
    scan_frame(20, 2'd1);
    check("fs_first", 32'(fs_first), 0);
    check("fs_count", 32'(fs_n), 1);
    check("line_period", 32'(rise_b - rise_a), 32'(H_T));
    check("first_vde_rise", 32'(rise_a), 0);
    check("vde_lines", 32'(vde_rises), 32'(V_A));
    check("vde_cycles", 32'(vde_n), 32'(H_A * V_A));
    check("hsync_start", 32'(hs_first), 134);
    check("hsync_cycles", 32'(hs_n), 32'(4 * V_T));
    check("vsync_start", 32'(vs_first), 32'(42 * H_T));
    check("vsync_cycles", 32'(vs_n), 32'(3 * H_T));
    check("hblank_cycles", 32'(hb_n), 32'(18 * V_T));
    check("vblank_cycles", 32'(vb_n), 32'(9 * H_T));
    check("blank_pixels", 32'(blank_px), 0);
    check("vde_consistency", 32'(de_bad), 0);
    check("bar_x0", {8'h0, fb[0][0]}, 32'hFFFFFF);
    check("bar_x16", {8'h0, fb[0][16]}, 32'hFFFF00);
    check("bar_x32", {8'h0, fb[3][32]}, 32'h00FFFF);
    check("bar_x80", {8'h0, fb[7][80]}, 32'hFF0000);
    check("bar_x127", {8'h0, fb[3][127]}, 32'h000000);
    check("bar_after_change", {8'h0, fb[30][16]}, 32'hFFFF00);

    // Frame 1: grey ramp; request checkerboard at line 10
    scan_frame(10, 2'd2);
    check("ramp_x5", {8'h0, fb[0][5]}, 32'h050505);
    check("ramp_x100", {8'h0, fb[10][100]}, 32'h646464);
    check("ramp_after_change", {8'h0, fb[20][100]}, 32'h646464);
    check("ramp_blank", {8'h0, fb[0][130]}, 32'h000000);

    // Frame 2: checkerboard; request solid grey
    scan_frame(5, 2'd3);
    check("chk_x32_y0", {8'h0, fb[0][32]}, 32'hFFFFFF);
    check("chk_x0_y0", {8'h0, fb[0][0]}, 32'h000000);
    check("chk_x32_y32", {8'h0, fb[32][32]}, 32'h000000);
    check("chk_x0_y33", {8'h0, fb[33][0]}, 32'hFFFFFF);
    check("chk_fs_count", 32'(fs_n), 1);

    // Async reset in mid-frame at h=60, v=25
    repeat (25 * H_T + 60 + 1) @(negedge Clock);
    check("pre_reset_vde", 32'(o_VDE), 1);
    check("pre_reset_pix", {8'h0, o_pixelData}, 32'h808080);
    #3 Reset = 1'b0;
    #1 check("async_reset_idle", out_vec(), IDLE_VEC);
    @(negedge Clock);
    Reset = 1'b1;
    scan_frame(-1, 2'd3);
    check("rst_fs_first", 32'(fs_first), 0);
    check("rst_fs_count", 32'(fs_n), 1);
    check("rst_line_period", 32'(rise_b - rise_a), 32'(H_T));
    check("rst_vde_cycles", 32'(vde_n), 32'(H_A * V_A));
    check("rst_solid", {8'h0, fb[5][10]}, 32'h808080);

    // Enable drop in mid-frame at h=60, v=25
    repeat (25 * H_T + 60 + 1) @(negedge Clock);
    i_Pattern = 2'd0;
    i_Enable  = 1'b0;
    @(negedge Clock);
    check("disable_idle", out_vec(), IDLE_VEC);
    repeat (3) @(negedge Clock);
    check("disable_hold", out_vec(), IDLE_VEC);
    i_Enable = 1'b1;
    scan_frame(-1, 2'd0);
    check("en_fs_first", 32'(fs_first), 0);
    check("en_fs_count", 32'(fs_n), 1);
    check("en_line_period", 32'(rise_b - rise_a), 32'(H_T));
    check("en_hsync_start", 32'(hs_first), 134);
    check("en_bars", {8'h0, fb[0][16]}, 32'hFFFF00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
